// File: rtl/iommu_hpm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : iommu_hpm_pkg
// Description : Shared constants and helpers for the IOMMU HPM event filter.
//               Event IDs, event-vector width, tag widths, and the DID
//               compare helper with optional DMASK range matching.
// Revision    : 1.0 - initial release
// ============================================================================
package iommu_hpm_pkg;

  // Event-vector and tag widths
  localparam int unsigned N_EVENTS = 9;
  localparam int unsigned EVT_ID_W = 15;
  localparam int unsigned DID_W    = 24;
  localparam int unsigned PID_W    = 20;
  localparam int unsigned GSCID_W  = 16;
  localparam int unsigned PSCID_W  = 20;

  // Event IDs (index into the event pulse vector)
  localparam int unsigned UNTRANS_REQ = 1;
  localparam int unsigned TRANS_REQ   = 2;
  localparam int unsigned ATS_REQ     = 3;
  localparam int unsigned TLB_MISS    = 4;
  localparam int unsigned DDT_WALK    = 5;
  localparam int unsigned PDT_WALK    = 6;
  localparam int unsigned S1_PTW      = 7;
  localparam int unsigned G_PTW       = 8;

  // Implemented event bits; bit 0 (eventID 0) is never an event.
  localparam logic [N_EVENTS-1:0] EVT_IMPL_MASK = N_EVENTS'(
      (1 << UNTRANS_REQ) | (1 << TRANS_REQ) | (1 << ATS_REQ)  | (1 << TLB_MISS) |
      (1 << DDT_WALK)    | (1 << PDT_WALK)  | (1 << S1_PTW)   | (1 << G_PTW));

  // DID compare. With masking, the trailing ones of the reference plus the
  // next zero bit become don't-care, giving a naturally aligned range.
  function automatic logic did_match(input logic [DID_W-1:0] did,
                                     input logic [DID_W-1:0] ref_did,
                                     input logic             masked);
    logic [DID_W-1:0] m;
    m = masked ? (ref_did ^ (ref_did + DID_W'(1))) : '0;
    return ((did & ~m) == (ref_did & ~m));
  endfunction

endpackage
`default_nettype wire

// File: rtl/iommu_hpm_evt_match.sv
`default_nettype none
// ============================================================================
// Module      : iommu_hpm_evt_match
// Description : Combinational matcher for one HPM counter. Selects the
//               programmed event from the stage-1 event vector and applies
//               the device / process (or GSCID / PSCID) filters.
// Optional    : IOMMU_HPM_DMASK_EN enables DMASK range matching on DID.
// Ports       : ev_i, did_i, pid_i, pv_i, gscid_i, gscv_i, pscid_i, pscv_i
//                 - stage-1 event vector and transaction tags
//               evt_*_i - this counter's iohpmevt fields
//               match_o - event hit and all enabled filters pass
// Revision    : 1.0 - initial release
// ============================================================================
module iommu_hpm_evt_match
  import iommu_hpm_pkg::*;
(
  input  logic [N_EVENTS-1:0] ev_i,
  input  logic [DID_W-1:0]    did_i,
  input  logic [PID_W-1:0]    pid_i,
  input  logic                pv_i,
  input  logic [GSCID_W-1:0]  gscid_i,
  input  logic                gscv_i,
  input  logic [PSCID_W-1:0]  pscid_i,
  input  logic                pscv_i,
  input  logic [EVT_ID_W-1:0] evt_id_i,
  input  logic                evt_dmask_i,
  input  logic [PID_W-1:0]    evt_pid_pscid_i,
  input  logic [DID_W-1:0]    evt_did_gscid_i,
  input  logic                evt_pv_pscv_i,
  input  logic                evt_dv_gscv_i,
  input  logic                evt_idt_i,
  output logic                match_o
);

  localparam int unsigned IDX_W = $clog2(N_EVENTS);
  localparam int unsigned EXT_W = 1 << IDX_W;

  logic [EXT_W-1:0] w_ev_ext;
  logic             w_id_in_range;
  logic             w_hit;
  logic             w_use_mask;
  logic             w_dv_ok;
  logic             w_pv_ok;

  // Pad the event vector to a power of two so the low eventID bits can
  // index it directly; the range check rejects IDs that alias into padding.
  assign w_ev_ext      = {{(EXT_W - N_EVENTS){1'b0}}, ev_i};
  assign w_id_in_range = (evt_id_i != '0) && (evt_id_i < EVT_ID_W'(N_EVENTS));
  assign w_hit         = w_id_in_range & w_ev_ext[evt_id_i[IDX_W-1:0]];

`ifdef IOMMU_HPM_DMASK_EN
  // DMASK only applies to device-ID compares (IDT=0).
  assign w_use_mask = evt_dmask_i & ~evt_idt_i;
`else
  logic unused_dmask;
  assign unused_dmask = evt_dmask_i;
  assign w_use_mask   = 1'b0;
`endif

  always_comb begin
    w_dv_ok = 1'b1;
    w_pv_ok = 1'b1;
    if (evt_idt_i) begin
      if (evt_dv_gscv_i) w_dv_ok = gscv_i & (gscid_i == evt_did_gscid_i[GSCID_W-1:0]);
      if (evt_pv_pscv_i) w_pv_ok = pscv_i & (pscid_i == evt_pid_pscid_i);
    end else begin
      if (evt_dv_gscv_i) w_dv_ok = did_match(did_i, evt_did_gscid_i, w_use_mask);
      if (evt_pv_pscv_i) w_pv_ok = pv_i & (pid_i == evt_pid_pscid_i);
    end
  end

  assign match_o = w_hit & w_dv_ok & w_pv_ok;

endmodule
`default_nettype wire

// File: rtl/iommu_hpm_evt_filter.sv
`default_nettype none
// ============================================================================
// Module      : iommu_hpm_evt_filter
// Description : Event qualification stage in front of the IOMMU HPM counter
//               bank. Stage 1 registers raw events and tags; stage 2 matches
//               them against live iohpmevt programming and iocountinh, and
//               registers one increment pulse per counter (2-cycle latency).
// Optional    : IOMMU_HPM_DMASK_EN enables DMASK range matching on DID.
// Ports       : clk_i, rst_i (async, active-high)
//               ev_i, did_i, pid_i, pv_i, gscid_i, gscv_i, pscid_i, pscv_i
//                 - event pulses and transaction tags
//               evt_*_i - per-counter iohpmevt fields, packed by counter
//               cnt_inh_i - per-counter inhibit
//               inc_o   - per-counter increment pulse
// Revision    : 1.0 - initial release
// ============================================================================
module iommu_hpm_evt_filter
  import iommu_hpm_pkg::*;
#(
  parameter int unsigned N_IOHPMCTR = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_EVENTS-1:0]            ev_i,
  input  logic [DID_W-1:0]               did_i,
  input  logic [PID_W-1:0]               pid_i,
  input  logic                           pv_i,
  input  logic [GSCID_W-1:0]             gscid_i,
  input  logic                           gscv_i,
  input  logic [PSCID_W-1:0]             pscid_i,
  input  logic                           pscv_i,
  input  logic [N_IOHPMCTR*EVT_ID_W-1:0] evt_id_i,
  input  logic [N_IOHPMCTR-1:0]          evt_dmask_i,
  input  logic [N_IOHPMCTR*PID_W-1:0]    evt_pid_pscid_i,
  input  logic [N_IOHPMCTR*DID_W-1:0]    evt_did_gscid_i,
  input  logic [N_IOHPMCTR-1:0]          evt_pv_pscv_i,
  input  logic [N_IOHPMCTR-1:0]          evt_dv_gscv_i,
  input  logic [N_IOHPMCTR-1:0]          evt_idt_i,
  input  logic [N_IOHPMCTR-1:0]          cnt_inh_i,
  output logic [N_IOHPMCTR-1:0]          inc_o
);

  // Stage 1: unqualified capture of events and tags
  logic [N_EVENTS-1:0] ev_q;
  logic [DID_W-1:0]    did_q;
  logic [PID_W-1:0]    pid_q;
  logic                pv_q;
  logic [GSCID_W-1:0]  gscid_q;
  logic                gscv_q;
  logic [PSCID_W-1:0]  pscid_q;
  logic                pscv_q;

  // Stage 2
  logic [N_IOHPMCTR-1:0] w_match;
  logic [N_IOHPMCTR-1:0] inc_d;
  logic [N_IOHPMCTR-1:0] inc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ev_q    <= '0;
      did_q   <= '0;
      pid_q   <= '0;
      pv_q    <= 1'b0;
      gscid_q <= '0;
      gscv_q  <= 1'b0;
      pscid_q <= '0;
      pscv_q  <= 1'b0;
    end else begin
      // Bit 0 has no event behind it and is dropped here.
      ev_q    <= ev_i & EVT_IMPL_MASK;
      did_q   <= did_i;
      pid_q   <= pid_i;
      pv_q    <= pv_i;
      gscid_q <= gscid_i;
      gscv_q  <= gscv_i;
      pscid_q <= pscid_i;
      pscv_q  <= pscv_i;
    end
  end

  generate
    for (genvar k = 0; k < int'(N_IOHPMCTR); k++) begin : g_ctr
      iommu_hpm_evt_match u_match (
        .ev_i            (ev_q),
        .did_i           (did_q),
        .pid_i           (pid_q),
        .pv_i            (pv_q),
        .gscid_i         (gscid_q),
        .gscv_i          (gscv_q),
        .pscid_i         (pscid_q),
        .pscv_i          (pscv_q),
        .evt_id_i        (evt_id_i[k*EVT_ID_W +: EVT_ID_W]),
        .evt_dmask_i     (evt_dmask_i[k]),
        .evt_pid_pscid_i (evt_pid_pscid_i[k*PID_W +: PID_W]),
        .evt_did_gscid_i (evt_did_gscid_i[k*DID_W +: DID_W]),
        .evt_pv_pscv_i   (evt_pv_pscv_i[k]),
        .evt_dv_gscv_i   (evt_dv_gscv_i[k]),
        .evt_idt_i       (evt_idt_i[k]),
        .match_o         (w_match[k])
      );
    end
  endgenerate

  // Config and inhibit are taken live in S2, so a write in the same cycle
  // already governs the event currently held in S1.
  assign inc_d = w_match & ~cnt_inh_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) inc_q <= '0;
    else       inc_q <= inc_d;
  end

  assign inc_o = inc_q;

endmodule
`default_nettype wire

// File: tb/tb_iommu_hpm_evt_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_iommu_hpm_evt_filter
// Description : Self-checking bench for iommu_hpm_evt_filter. Expected
//               increment vectors are queued when stimulus is applied and
//               popped two cycles later when the DUT output is due.
//               Expectations follow IOMMU_HPM_DMASK_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iommu_hpm_evt_filter;
  import iommu_hpm_pkg::*;

  localparam int N = 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [8:0]        ev_i;
  logic [23:0]       did_i;
  logic [19:0]       pid_i;
  logic              pv_i;
  logic [15:0]       gscid_i;
  logic              gscv_i;
  logic [19:0]       pscid_i;
  logic              pscv_i;
  logic [N*15-1:0]   evt_id_i;
  logic [N-1:0]      evt_dmask_i;
  logic [N*20-1:0]   evt_pid_pscid_i;
  logic [N*24-1:0]   evt_did_gscid_i;
  logic [N-1:0]      evt_pv_pscv_i;
  logic [N-1:0]      evt_dv_gscv_i;
  logic [N-1:0]      evt_idt_i;
  logic [N-1:0]      cnt_inh_i;
  logic [N-1:0]      inc_o;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] e;
  int n_vec = 0;
  int n_err = 0;

  iommu_hpm_evt_filter #(.N_IOHPMCTR(N)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ev_i(ev_i), .did_i(did_i), .pid_i(pid_i),
    .pv_i(pv_i), .gscid_i(gscid_i), .gscv_i(gscv_i), .pscid_i(pscid_i),
    .pscv_i(pscv_i), .evt_id_i(evt_id_i), .evt_dmask_i(evt_dmask_i),
    .evt_pid_pscid_i(evt_pid_pscid_i), .evt_did_gscid_i(evt_did_gscid_i),
    .evt_pv_pscv_i(evt_pv_pscv_i), .evt_dv_gscv_i(evt_dv_gscv_i),
    .evt_idt_i(evt_idt_i), .cnt_inh_i(cnt_inh_i), .inc_o(inc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic clear_inputs();
    ev_i = '0; did_i = '0; pid_i = '0; pv_i = 1'b0; gscid_i = '0; gscv_i = 1'b0;
    pscid_i = '0; pscv_i = 1'b0; cnt_inh_i = '0;
  endtask

  task automatic clear_cfg();
    evt_id_i = '0; evt_dmask_i = '0; evt_pid_pscid_i = '0; evt_did_gscid_i = '0;
    evt_pv_pscv_i = '0; evt_dv_gscv_i = '0; evt_idt_i = '0;
  endtask

  task automatic cfg(input int k, input logic [14:0] id, input logic idt, input logic dv,
                     input logic pv, input logic dm, input logic [23:0] didg,
                     input logic [19:0] pidp);
    evt_id_i[k*15 +: 15]        = id;
    evt_idt_i[k]                = idt;
    evt_dv_gscv_i[k]            = dv;
    evt_pv_pscv_i[k]            = pv;
    evt_dmask_i[k]              = dm;
    evt_did_gscid_i[k*24 +: 24] = didg;
    evt_pid_pscid_i[k*20 +: 20] = pidp;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    clear_inputs();
    clear_cfg();
    cfg(0, 15'd4, 0, 0, 0, 0, 24'h0, 20'h0);
    cfg(1, 15'd1, 0, 0, 0, 0, 24'h0, 20'h0);
    ev_i = 9'h1FE;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      n_vec++;
      if (inc_o !== '0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: inc_o=%h expected %h", i, inc_o, {N{1'b0}});
      end
    end
    rst_i = 1'b0;
    ev_i  = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      n_vec++;
      if (inc_o !== '0) begin
        n_err++;
        $display("FAIL reset_release[%0d]: inc_o=%h expected %h", i, inc_o, {N{1'b0}});
      end
    end
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  task automatic test_basic();
    logic [8:0] evs [10] = '{9'h010, 9'h000, 9'h000, 9'h010, 9'h010, 9'h010,
                             9'h000, 9'h0EE, 9'h000, 9'h000};
    clear_cfg();
    cfg(0, 15'd4, 0, 0, 0, 0, 24'h0, 20'h0);
    for (int i = 0; i < 10; i++) begin
      ev_i = evs[i]; did_i = 24'($urandom()); pid_i = 20'($urandom()); pv_i = 1'($urandom());
      exp_q.push_back(evs[i][4] ? 8'h01 : 8'h00);
      @(posedge clk_i); #1;
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front(); n_vec++;
        if (inc_o !== e) begin
          n_err++;
          $display("FAIL basic[%0d]: inc_o=%h expected %h", i, inc_o, e);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_device_filter();
    logic [8:0]  evs [12] = '{9'h004, 9'h004, 9'h010, 9'h000, 9'h1FF, 9'h1FF,
                              9'h1FF, 9'h000, 9'h000, 9'h1FF, 9'h001, 9'h000};
    logic [23:0] dids[12] = '{24'h000123, 24'h000124, 24'h000123, 24'h000123,
                              24'h000123, 24'h000123, 24'h000123, 24'h000123,
                              24'h000123, 24'h000123, 24'h000123, 24'h000123};
    logic [14:0] ids [12] = '{15'd2, 15'd2, 15'd2, 15'd2, 15'd0, 15'd9, 15'h4004,
                              15'h4004, 15'd2, 15'd2, 15'd2, 15'd2};
    logic [7:0]  exps[12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h02, 8'h00, 8'h00};
    clear_cfg();
    for (int i = 0; i < 12; i++) begin
      cfg(1, ids[i], 0, 1, 0, 0, 24'h000123, 20'h0);
      ev_i = evs[i]; did_i = dids[i];
      exp_q.push_back(exps[i]);
      @(posedge clk_i); #1;
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front(); n_vec++;
        if (inc_o !== e) begin
          n_err++;
          $display("FAIL device[%0d]: inc_o=%h expected %h", i, inc_o, e);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_dmask();
    logic [23:0] d;
    logic        hit;
    logic [23:0] far_dids[4] = '{24'h000000, 24'h123456, 24'hFFFFFF, 24'h000000};
    clear_cfg();
    cfg(1, 15'd2, 0, 1, 0, 1, 24'h000107, 20'h0);
    for (int i = 0; i < 19; i++) begin
      d = 24'h0000FF + 24'(i);
      ev_i = (i == 18) ? 9'h000 : 9'h004; did_i = d;
`ifdef IOMMU_HPM_DMASK_EN
      hit = (d[23:4] == 20'h00010);
`else
      hit = (d == 24'h000107);
`endif
      exp_q.push_back((hit && i != 18) ? 8'h02 : 8'h00);
      @(posedge clk_i); #1;
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front(); n_vec++;
        if (inc_o !== e) begin
          n_err++;
          $display("FAIL dmask_range did=%h: inc_o=%h expected %h", did_i, inc_o, e);
        end
      end
    end
    // All-ones reference: under DMASK every DID lies in the range.
    cfg(1, 15'd2, 0, 1, 0, 1, 24'hFFFFFF, 20'h0);
    for (int i = 0; i < 4; i++) begin
      ev_i = (i == 3) ? 9'h000 : 9'h004; did_i = far_dids[i];
`ifdef IOMMU_HPM_DMASK_EN
      hit = 1'b1;
`else
      hit = (far_dids[i] == 24'hFFFFFF);
`endif
      exp_q.push_back((hit && i != 3) ? 8'h02 : 8'h00);
      @(posedge clk_i); #1;
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front(); n_vec++;
        if (inc_o !== e) begin
          n_err++;
          $display("FAIL dmask_all did=%h: inc_o=%h expected %h", did_i, inc_o, e);
        end
      end
    end
    clear_inputs();
  endtask

  typedef struct packed {
    logic        act;
    logic [1:0]  ph;
    logic        pv;
    logic [19:0] pid;
    logic        pscv;
    logic [19:0] pscid;
    logic        gscv;
    logic [15:0] gscid;
    logic [7:0]  exp;
  } tag_row_t;

  task automatic test_tag_filters();
    tag_row_t rows [13] = '{
      '{1'b1, 2'd0, 1'b0, 20'h0,  1'b0, 20'h5,  1'b0, 16'h0,    8'h00},
      '{1'b1, 2'd0, 1'b0, 20'h0,  1'b1, 20'h5,  1'b0, 16'h0,    8'h02},
      '{1'b1, 2'd0, 1'b0, 20'h0,  1'b1, 20'h6,  1'b0, 16'h0,    8'h00},
      '{1'b1, 2'd0, 1'b1, 20'h5,  1'b0, 20'h5,  1'b0, 16'h0,    8'h00},
      '{1'b0, 2'd0, 1'b0, 20'h0,  1'b0, 20'h0,  1'b0, 16'h0,    8'h00},
      '{1'b1, 2'd1, 1'b0, 20'h0,  1'b0, 20'h0,  1'b1, 16'h0033, 8'h02},
      '{1'b1, 2'd1, 1'b0, 20'h0,  1'b0, 20'h0,  1'b0, 16'h0033, 8'h00},
      '{1'b1, 2'd1, 1'b0, 20'h0,  1'b0, 20'h0,  1'b1, 16'h0034, 8'h00},
      '{1'b0, 2'd1, 1'b0, 20'h0,  1'b0, 20'h0,  1'b0, 16'h0,    8'h00},
      '{1'b1, 2'd2, 1'b1, 20'h77, 1'b0, 20'h0,  1'b0, 16'h0,    8'h02},
      '{1'b1, 2'd2, 1'b0, 20'h77, 1'b0, 20'h0,  1'b0, 16'h0,    8'h00},
      '{1'b1, 2'd2, 1'b1, 20'h78, 1'b1, 20'h77, 1'b0, 16'h0,    8'h00},
      '{1'b0, 2'd2, 1'b0, 20'h0,  1'b0, 20'h0,  1'b0, 16'h0,    8'h00}};
    clear_cfg();
    for (int i = 0; i < 13; i++) begin
      case (rows[i].ph)
        2'd0:    cfg(1, 15'd2, 1, 0, 1, 0, 24'h000000, 20'h00005);
        2'd1:    cfg(1, 15'd2, 1, 1, 0, 0, 24'hAB0033, 20'h00000);
        default: cfg(1, 15'd2, 0, 0, 1, 0, 24'h000000, 20'h00077);
      endcase
      ev_i    = rows[i].act ? 9'h004 : 9'h000;
      did_i   = 24'hAB0033;
      pv_i    = rows[i].pv;   pid_i   = rows[i].pid;
      pscv_i  = rows[i].pscv; pscid_i = rows[i].pscid;
      gscv_i  = rows[i].gscv; gscid_i = rows[i].gscid;
      exp_q.push_back(rows[i].exp);
      @(posedge clk_i); #1;
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front(); n_vec++;
        if (inc_o !== e) begin
          n_err++;
          $display("FAIL tags[%0d]: inc_o=%h expected %h", i, inc_o, e);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_inhibit();
    logic [8:0]  evs [10] = '{9'h012, 9'h000, 9'h012, 9'h000, 9'h002, 9'h000,
                              9'h000, 9'h002, 9'h000, 9'h000};
    logic [7:0]  inhs[10] = '{8'h02, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00,
                              8'h01, 8'h01, 8'h00};
    logic [14:0] id0 [10] = '{15'd1, 15'd1, 15'd1, 15'd1, 15'd1, 15'd4, 15'd1,
                              15'd1, 15'd1, 15'd1};
    logic [7:0]  exps[10] = '{8'h01, 8'h00, 8'h03, 8'h00, 8'h02, 8'h00, 8'h00,
                              8'h02, 8'h00, 8'h00};
    clear_cfg();
    cfg(1, 15'd1, 0, 0, 0, 0, 24'h0, 20'h0);
    for (int i = 0; i < 10; i++) begin
      cfg(0, id0[i], 0, 0, 0, 0, 24'h0, 20'h0);
      ev_i = evs[i]; cnt_inh_i = inhs[i];
      exp_q.push_back(exps[i]);
      @(posedge clk_i); #1;
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front(); n_vec++;
        if (inc_o !== e) begin
          n_err++;
          $display("FAIL inhibit[%0d]: inc_o=%h expected %h", i, inc_o, e);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [8:0] ev;
    logic [23:0] d;
    clear_cfg();
    cfg(0, 15'd4, 0, 0, 0, 0, 24'h0, 20'h0);
    cfg(1, 15'd2, 0, 1, 0, 0, 24'h000123, 20'h0);
    cfg(2, 15'd8, 0, 0, 0, 0, 24'h0, 20'h0);
    for (int i = 0; i < 42; i++) begin
      ev = (i >= 40) ? 9'h000 : 9'($urandom());
      d  = $urandom_range(0, 1) ? 24'h000123 : 24'h000321;
      ev_i = ev; did_i = d;
      exp_q.push_back({5'b0, ev[8], ev[2] & (d == 24'h000123), ev[4]});
      @(posedge clk_i); #1;
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front(); n_vec++;
        if (inc_o !== e) begin
          n_err++;
          $display("FAIL b2b[%0d]: inc_o=%h expected %h", i, inc_o, e);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_midflight_reset();
    clear_cfg();
    cfg(0, 15'd4, 0, 0, 0, 0, 24'h0, 20'h0);
    ev_i = 9'h010;
    @(posedge clk_i); #1;
    ev_i  = '0;
    rst_i = 1'b1;
    #2;
    n_vec++;
    if (inc_o !== '0) begin
      n_err++;
      $display("FAIL midreset_assert: inc_o=%h expected %h", inc_o, {N{1'b0}});
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      n_vec++;
      if (inc_o !== '0) begin
        n_err++;
        $display("FAIL midreset_release[%0d]: inc_o=%h expected %h", i, inc_o, {N{1'b0}});
      end
    end
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_device_filter();
    test_dmask();
    test_tag_filters();
    test_inhibit();
    test_back_to_back();
    test_midflight_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
